fp32_div_norm_round: RTL

- Downstream stage of the fp32 divider datapath.
- Consumes the divider's raw result: sign, unbounded biased exponent (E1-E2+127), and an unnormalised quotient significand with sticky.
- Normalises it iteratively, rounds to nearest-even, and handles overflow/underflow.
- Emits a packed IEEE-754 single plus exception flags over valid/ready handshakes.

---
 rtl/fp32_pkg.sv | 24 ++
 rtl/fp32_rne_round.sv | 29 ++
 rtl/fp32_div_norm_round.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 datapath definitions: controller states, IEEE-754 single
// constants and the field packing helper used by the divider and multiplier
// back ends.
package fp32_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DENORM,
        ROUND,
        HOLD
    } state_t;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP32_FRAC_W  = 23;

    function automatic logic [31:0] fp32_pack(input logic                   sign,
                                              input logic [7:0]             exp_field,
                                              input logic [FP32_FRAC_W-1:0] frac);
        return {sign, exp_field, frac};
    endfunction

endpackage

// File: rtl/fp32_rne_round.sv
// Round-to-nearest-even on a packed {exponent, fraction} field. The increment
// is applied to the packed word so a fraction carry bumps the exponent and a
// carry into exponent 255 lands exactly on infinity.
module fp32_rne_round
    import fp32_pkg::*;
(
    input  logic                   sign,
    input  logic [7:0]             exp_field,
    input  logic [FP32_FRAC_W-1:0] frac,
    input  logic                   guard,
    input  logic                   sticky,
    output logic [31:0]            result,
    output logic                   overflow,
    output logic                   inexact
);

    logic        round_up;
    logic [30:0] rounded;

    // Packed increment, carry into exponent, overflow and inexact detection
    always_comb begin
        round_up = guard & (sticky | frac[0]);
        rounded  = {exp_field, frac} + {30'd0, round_up};
        result   = fp32_pack(sign, rounded[30:23], rounded[22:0]);
        overflow = (exp_field != 8'hFF) && (rounded[30:23] == 8'hFF);
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/fp32_div_norm_round.sv
// fp32 divider back end: normalises the raw quotient one shift per cycle,
// rounds to nearest-even and packs an IEEE-754 single with exception flags.
// Define FP_DIV_SUBNORM_EN to produce subnormal results (gradual underflow);
// otherwise tiny results flush to signed zero.
//
// state  | meaning
// IDLE   | waiting for a quotient, in_ready high
// NORM   | left-shifting until the 2^0 bit is set
// DENORM | right-shifting a tiny result up to exponent 1 (subnormal build only)
// ROUND  | rounding and special-case selection, result registered
// HOLD   | result presented until downstream accepts
module fp32_div_norm_round
    import fp32_pkg::*;
#(
    parameter int MW = 26,
    parameter int EW = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [EW-1:0] in_exp,
    input  logic [MW-1:0]        in_mant,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic                 out_inexact
);

    localparam logic signed [EW-1:0] EXP_ZERO  = '0;
    localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX_S = EW'(FP32_EXP_MAX);
    // Anything below this is far past the smallest subnormal; clamping keeps
    // the NORM decrements from wrapping the EW-bit exponent.
    localparam logic signed [EW-1:0] EXP_DEEP  = EW'(-(MW + 2));

    state_t                state, state_nxt;
    logic                  sign_r, sticky_r, zero_r;
    logic signed [EW-1:0]  exp_r;
    logic [MW-1:0]         mant_r;
    logic [31:0]           result_r;
    logic                  ovf_r, unf_r, inx_r;
`ifdef FP_DIV_SUBNORM_EN
    localparam int CW = $clog2(MW + 2);
    logic [CW-1:0]         cnt_r;
`endif

    logic [7:0]             exp_field;
    logic [FP32_FRAC_W-1:0] frac;
    logic                   guard, sticky_all;
    logic [31:0]            rne_result;
    logic                   rne_ovf, rne_inx;
    logic [31:0]            res_nxt;
    logic                   ovf_nxt, unf_nxt, inx_nxt;

    assign in_ready      = rst_n && (state == IDLE);
    assign out_valid     = (state == HOLD);
    assign out_result    = result_r;
    assign out_overflow  = ovf_r;
    assign out_underflow = unf_r;
    assign out_inexact   = inx_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = (in_mant == '0) ? ROUND : NORM;
            NORM: begin
                if (mant_r[MW-1]) begin
`ifdef FP_DIV_SUBNORM_EN
                    state_nxt = (exp_r <= EXP_ZERO) ? DENORM : ROUND;
`else
                    state_nxt = ROUND;
`endif
                end
            end
`ifdef FP_DIV_SUBNORM_EN
            // The shift that brings the exponent to 1, or the last allowed shift, exits
            DENORM: if (exp_r == EXP_ZERO || cnt_r == CW'(MW)) state_nxt = ROUND;
`endif
            ROUND:  state_nxt = HOLD;
            HOLD:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Rounding operands taken from the normalised (or denormalised) quotient
    always_comb begin
        exp_field  = mant_r[MW-1] ? exp_r[7:0] : 8'd0;
        frac       = mant_r[MW-2 -: FP32_FRAC_W];
        guard      = mant_r[MW-25];
        sticky_all = (|mant_r[MW-26:0]) | sticky_r;
    end

    fp32_rne_round u_round (
        .sign      (sign_r),
        .exp_field (exp_field),
        .frac      (frac),
        .guard     (guard),
        .sticky    (sticky_all),
        .result    (rne_result),
        .overflow  (rne_ovf),
        .inexact   (rne_inx)
    );

    // Special-result selection ahead of the output registers
    always_comb begin
        res_nxt = rne_result;
        ovf_nxt = rne_ovf;
        inx_nxt = rne_inx;
        unf_nxt = (exp_field == 8'd0) && rne_inx;
        if (zero_r) begin
            res_nxt = fp32_pack(sign_r, 8'h00, '0);
            ovf_nxt = 1'b0;
            inx_nxt = 1'b0;
            unf_nxt = 1'b0;
        end else if (exp_r >= EXP_MAX_S) begin
            res_nxt = fp32_pack(sign_r, 8'hFF, '0);
            ovf_nxt = 1'b1;
            inx_nxt = 1'b1;
            unf_nxt = 1'b0;
`ifndef FP_DIV_SUBNORM_EN
        end else if (exp_r <= EXP_ZERO) begin
            res_nxt = fp32_pack(sign_r, 8'h00, '0);
            ovf_nxt = 1'b0;
            inx_nxt = 1'b1;
            unf_nxt = 1'b1;
`endif
        end
    end

    // Datapath: capture, shift and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            sticky_r <= 1'b0;
            zero_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= '0;
            result_r <= '0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            inx_r    <= 1'b0;
`ifdef FP_DIV_SUBNORM_EN
            cnt_r    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_r   <= in_sign;
                        exp_r    <= (in_exp < EXP_DEEP) ? EXP_DEEP : in_exp;
                        mant_r   <= in_mant;
                        sticky_r <= in_sticky;
                        zero_r   <= (in_mant == '0);
`ifdef FP_DIV_SUBNORM_EN
                        cnt_r    <= '0;
`endif
                    end
                end
                NORM: begin
                    if (!mant_r[MW-1]) begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - EXP_ONE;
                    end
                end
`ifdef FP_DIV_SUBNORM_EN
                DENORM: begin
                    if (cnt_r == CW'(MW)) begin
                        mant_r   <= '0;
                        sticky_r <= sticky_r | (|mant_r);
                        exp_r    <= EXP_ONE;
                    end else begin
                        mant_r   <= mant_r >> 1;
                        sticky_r <= sticky_r | mant_r[0];
                        exp_r    <= exp_r + EXP_ONE;
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
`endif
                ROUND: begin
                    result_r <= res_nxt;
                    ovf_r    <= ovf_nxt;
                    unf_r    <= unf_nxt;
                    inx_r    <= inx_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
